// File: rtl/monobit_sched.sv
// monobit_sched: run-level controller for the monobit frequency-test core.
// Frames a valid/ready bit stream into BLOCK_LEN-bit blocks, clears and feeds
// the core once per block, tallies verdicts and reports a run verdict after
// NUM_BLOCKS blocks.
// Optional build macro MONOBIT_SCHED_TIMEOUT_EN adds a WAIT-state watchdog
// (TIMEOUT cycles) that sets sticky timeout_err and scores the block as a fail.
module monobit_sched #(
   parameter int BLOCK_LEN  = 128,
   parameter int NUM_BLOCKS = 16,
   parameter int MAX_FAIL   = 2,
   parameter int TIMEOUT    = 1024,
   localparam int CW        = $clog2(NUM_BLOCKS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          bit_in,
   input  logic          bit_vld,
   output logic          bit_rdy,
   output logic          core_clr,
   output logic          core_bit,
   output logic          core_bit_vld,
   input  logic          core_done,
   input  logic          core_is_random,
   output logic          busy,
   output logic          run_done,
   output logic          run_pass,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic          timeout_err
);

   localparam int BW = $clog2(BLOCK_LEN + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      WAIT,
      TALLY,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [BW-1:0] bit_cnt;
   logic [CW-1:0] blk_cnt;
   logic          verdict_q;
   logic          xfer;
   logic          abort_hit;
   logic          start_hit;
   logic          timeout_hit;

   assign xfer      = bit_vld & bit_rdy;
   assign abort_hit = abort & (state != IDLE);
   assign start_hit = (state == IDLE) & start & ~abort;

   // Next-state and state-decoded outputs; abort overrides every transition
   always_comb begin
      state_nxt = state;
      bit_rdy   = 1'b0;
      run_done  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:  if (start_hit) state_nxt = CLEAR;
         CLEAR: state_nxt = FEED;
         FEED: begin
            bit_rdy = 1'b1;
            if (xfer && (bit_cnt == BW'(BLOCK_LEN - 1))) state_nxt = WAIT;
         end
         WAIT:  if (core_done || timeout_hit) state_nxt = TALLY;
         TALLY: state_nxt = (blk_cnt == CW'(NUM_BLOCKS - 1)) ? DONE : CLEAR;
         DONE: begin
            run_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_hit) state_nxt = IDLE;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Core-side registered outputs: clear pulse, bit and qualifier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_clr     <= 1'b0;
         core_bit     <= 1'b0;
         core_bit_vld <= 1'b0;
      end else begin
         // clear lands in the CLEAR cycle, or in the first IDLE cycle after abort
         core_clr     <= (state_nxt == CLEAR) | abort_hit;
         core_bit_vld <= xfer & ~abort;
         if (xfer) core_bit <= bit_in;
      end
   end

   // Bit, block and result counters plus verdict latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         blk_cnt   <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         run_pass  <= 1'b0;
         verdict_q <= 1'b0;
      end else begin
         if (state == CLEAR)  bit_cnt <= '0;
         else if (xfer)       bit_cnt <= bit_cnt + BW'(1);

         if (start_hit) begin
            blk_cnt  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            run_pass <= 1'b0;
         end else if (!abort) begin
            case (state)
               WAIT: begin
                  if (core_done)        verdict_q <= core_is_random;
                  else if (timeout_hit) verdict_q <= 1'b0;
               end
               TALLY: begin
                  if (verdict_q) pass_cnt <= pass_cnt + CW'(1);
                  else           fail_cnt <= fail_cnt + CW'(1);
                  blk_cnt <= blk_cnt + CW'(1);
               end
               DONE: run_pass <= (int'(fail_cnt) <= MAX_FAIL);
               default: ;
            endcase
         end
      end
   end

`ifdef MONOBIT_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT) & ~core_done & (wait_cnt == TW'(TIMEOUT - 1));

   // WAIT-cycle counter and sticky watchdog flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != WAIT) wait_cnt <= '0;
         else               wait_cnt <= wait_cnt + TW'(1);
         if (start_hit)                  timeout_err <= 1'b0;
         else if (timeout_hit && !abort) timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_monobit_sched.sv
// tb_monobit_sched: directed bench for monobit_sched with BLOCK_LEN=8,
// NUM_BLOCKS=4, MAX_FAIL=1, TIMEOUT=16. The bench plays both the bit source
// and the monobit core. Timeout scenario runs when MONOBIT_SCHED_TIMEOUT_EN
// is defined for the build.
module tb_monobit_sched;

   localparam int CW = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          bit_in;
   logic          bit_vld;
   logic          bit_rdy;
   logic          core_clr;
   logic          core_bit;
   logic          core_bit_vld;
   logic          core_done;
   logic          core_is_random;
   logic          busy;
   logic          run_done;
   logic          run_pass;
   logic [CW-1:0] pass_cnt;
   logic [CW-1:0] fail_cnt;
   logic          timeout_err;

   int checks   = 0;
   int failures = 0;

   // monitor-owned observations
   int   clr_cnt = 0;
   int   rd_cnt  = 0;
   logic obs_q[$];
   // driver-owned expectations and snapshots
   logic exp_q[$];
   int   clr0, rd0, obs0, exp0;

   monobit_sched #(
      .BLOCK_LEN (8),
      .NUM_BLOCKS(4),
      .MAX_FAIL  (1),
      .TIMEOUT   (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .bit_in        (bit_in),
      .bit_vld       (bit_vld),
      .bit_rdy       (bit_rdy),
      .core_clr      (core_clr),
      .core_bit      (core_bit),
      .core_bit_vld  (core_bit_vld),
      .core_done     (core_done),
      .core_is_random(core_is_random),
      .busy          (busy),
      .run_done      (run_done),
      .run_pass      (run_pass),
      .pass_cnt      (pass_cnt),
      .fail_cnt      (fail_cnt),
      .timeout_err   (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Record core-side pulses and bits away from the active edge
   always @(negedge clk) begin
      if (core_clr)     clr_cnt <= clr_cnt + 1;
      if (run_done)     rd_cnt  <= rd_cnt + 1;
      if (core_bit_vld) obs_q.push_back(core_bit);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      clr0 = clr_cnt;
      rd0  = rd_cnt;
      obs0 = obs_q.size();
      exp0 = exp_q.size();
   endtask

   task automatic cmp_bits();
      int n;
      n = exp_q.size() - exp0;
      chk("bit_count", obs_q.size() - obs0, n);
      for (int i = 0; i < n; i++)
         if (obs0 + i < obs_q.size()) chk("core_bit", obs_q[obs0 + i], exp_q[exp0 + i]);
   endtask

   task automatic feed_bits(input int n, input bit bp, input bit stray);
      int sent  = 0;
      int guard = 0;
      while (sent < n && guard < 400) begin
         @(negedge clk);
         guard++;
         core_done = 1'b0;
         start     = 1'b0;
         if (stray && sent == 3) begin
            core_done      = 1'b1;
            core_is_random = 1'b0;
            start          = 1'b1;
         end
         bit_vld = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bit_in  = 1'($urandom_range(0, 1));
         if (bit_vld && bit_rdy) begin
            exp_q.push_back(bit_in);
            sent++;
         end
      end
      chk("feed_count", sent, n);
   endtask

   task automatic give_verdict(input logic v);
      repeat (2) @(negedge clk);
      core_done      = 1'b1;
      core_is_random = v;
      @(negedge clk);
      core_done = 1'b0;
   endtask

   task automatic do_run(input logic [3:0] verd, input bit bp, input bit stray, input int hold_blk);
      int g = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int b = 0; b < 4; b++) begin
         feed_bits(8, bp, stray && b == 0);
         @(negedge clk);
         bit_vld = 1'b0;
         start   = 1'b0;
         if (b == hold_blk) begin
            repeat (15) @(negedge clk);
            chk("timeout_early", timeout_err, 0);
            @(negedge clk);
            chk("timeout_set", timeout_err, 1);
         end else begin
            give_verdict(verd[b]);
         end
      end
      while (!run_done && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("run_done_seen", run_done, 1);
      @(negedge clk);
   endtask

   task automatic end_checks(input int ep, input int ef, input int erp);
      chk("pass_cnt", pass_cnt, ep);
      chk("fail_cnt", fail_cnt, ef);
      chk("run_pass", run_pass, erp);
      chk("busy_after", busy, 0);
      chk("clr_pulses", clr_cnt - clr0, 4);
      chk("run_done_pulses", rd_cnt - rd0, 1);
      cmp_bits();
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      abort          = 1'b0;
      bit_in         = 1'b0;
      bit_vld        = 1'b0;
      core_done      = 1'b0;
      core_is_random = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_bit_rdy", bit_rdy, 0);
      chk("rst_core_clr", core_clr, 0);
      chk("rst_core_bit", core_bit, 0);
      chk("rst_core_bit_vld", core_bit_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_run_pass", run_pass, 0);
      chk("rst_pass_cnt", pass_cnt, 0);
      chk("rst_fail_cnt", fail_cnt, 0);
      chk("rst_timeout_err", timeout_err, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      // nominal run: verdicts 1,1,0,1 -> 3 pass, 1 fail, run passes
      snap();
      do_run(4'b1011, 1'b0, 1'b0, -1);
      end_checks(3, 1, 1);

      // same verdicts with random source backpressure
      snap();
      do_run(4'b1011, 1'b1, 1'b0, -1);
      end_checks(3, 1, 1);

      // verdicts 0,0,1,0 -> 1 pass, 3 fail, run fails
      snap();
      do_run(4'b0100, 1'b1, 1'b0, -1);
      end_checks(1, 3, 0);

      // abort after 5 bits of block 2 (block 1 passed)
      snap();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      feed_bits(8, 1'b0, 1'b0);
      @(negedge clk) bit_vld = 1'b0;
      give_verdict(1'b1);
      feed_bits(5, 1'b0, 1'b0);
      @(negedge clk);
      bit_vld = 1'b0;
      abort   = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_core_clr", core_clr, 1);
      chk("abort_core_bit_vld", core_bit_vld, 0);
      chk("abort_bit_rdy", bit_rdy, 0);
      repeat (5) @(negedge clk);
      chk("abort_no_run_done", rd_cnt - rd0, 0);
      chk("abort_clr_pulses", clr_cnt - clr0, 3);
      chk("abort_pass_kept", pass_cnt, 1);
      chk("abort_fail_kept", fail_cnt, 0);
      chk("abort_run_pass", run_pass, 0);
      chk("abort_core_clr_once", core_clr, 0);
      cmp_bits();

      // following run starts from cleared counters
      snap();
      do_run(4'b1111, 1'b0, 1'b0, -1);
      end_checks(4, 0, 1);

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", busy, 0);
      chk("start_abort_hold", pass_cnt, 4);

      // stray core_done (verdict 0) and start during FEED are ignored
      snap();
      do_run(4'b1111, 1'b0, 1'b1, -1);
      end_checks(4, 0, 1);

`ifdef MONOBIT_SCHED_TIMEOUT_EN
      // block 1 core verdict withheld: watchdog scores it as a fail
      snap();
      do_run(4'b1111, 1'b0, 1'b0, 0);
      end_checks(3, 1, 1);
      chk("timeout_sticky", timeout_err, 1);
`else
      chk("timeout_tied_low", timeout_err, 0);
`endif

      // reset mid-run: immediate return to reset state, no run_done
      snap();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      feed_bits(8, 1'b0, 1'b0);
      @(negedge clk) bit_vld = 1'b0;
      give_verdict(1'b1);
      feed_bits(3, 1'b0, 1'b0);
      @(negedge clk);
      bit_vld = 1'b0;
      rst_n   = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_bit_rdy", bit_rdy, 0);
      chk("mid_rst_pass_cnt", pass_cnt, 0);
      chk("mid_rst_core_bit_vld", core_bit_vld, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_run_done", rd_cnt - rd0, 0);
      chk("mid_rst_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/monobit_sched.md
Name: monobit_sched

Overview:
- Run-level controller for the monobit frequency-test core.
- Accepts a valid/ready serial bit stream and frames it into fixed-length blocks.
- For each block: clears the core, feeds it exactly BLOCK_LEN bits, waits for the core's valid verdict, then tallies pass/fail.
- After NUM_BLOCKS blocks, reports an overall run verdict. Sits between the entropy-source sampler and the monobit core inside the top-level wrapper.

Parameters:
- BLOCK_LEN, 128, bits fed to the core per test block (>=2).
- NUM_BLOCKS, 16, blocks per run (>=1).
- MAX_FAIL, 2, largest fail count that still yields run_pass=1.
- TIMEOUT, 1024, cycles allowed in WAIT before declaring an error (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle
- abort  in  1  synchronous abort, returns to IDLE
- bit_in  in  1  source data bit
- bit_vld  in  1  source bit valid
- bit_rdy  out  1  ready to source
- core_clr  out  1  one-cycle synchronous clear to the core
- core_bit  out  1  registered bit to the core
- core_bit_vld  out  1  registered qualifier for core_bit
- core_done  in  1  core verdict valid (single-cycle pulse)
- core_is_random  in  1  core verdict, sampled when core_done=1
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle pulse at end of run
- run_pass  out  1  fail_cnt <= MAX_FAIL, updated at run end
- pass_cnt  out  CW  blocks passed; CW = $clog2(NUM_BLOCKS+1)
- fail_cnt  out  CW  blocks failed
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n=0):
  - FSM enters IDLE.
  - All outputs are 0: bit_rdy, core_clr, core_bit, core_bit_vld, busy, run_done, run_pass, pass_cnt, fail_cnt, timeout_err.
  - Internal counters are cleared.
- States: IDLE, CLEAR, FEED, WAIT, TALLY, DONE.
- IDLE:
  - bit_rdy=0.
  - On start=1: clear pass_cnt, fail_cnt, run_pass, timeout_err and the block counter, then go to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - core_clr=1 for exactly this one cycle; bit counter cleared.
  - Next state is FEED.
- FEED:
  - bit_rdy=1 combinationally.
  - A transfer occurs on bit_vld & bit_rdy. On the following cycle core_bit=bit_in and core_bit_vld=1 (1-cycle latency); otherwise core_bit_vld=0.
  - The bit counter increments per transfer. When the transfer that reaches BLOCK_LEN occurs, go to WAIT. bit_rdy is 0 from the next cycle, so exactly BLOCK_LEN bits are accepted.
- WAIT:
  - bit_rdy=0; core_bit_vld still shows the final bit in the first WAIT cycle.
  - On core_done=1, latch core_is_random and go to TALLY.
  - core_done seen in any state other than WAIT is ignored.
- TALLY:
  - pass_cnt++ if the latched verdict is 1, else fail_cnt++.
  - Block counter increments. If it now equals NUM_BLOCKS go to DONE, else go to CLEAR.
- DONE:
  - run_done=1 for one cycle; run_pass registered as (fail_cnt <= MAX_FAIL).
  - Next state is IDLE.
- Result holding: pass_cnt, fail_cnt, run_pass and timeout_err hold until the next accepted start.
- Invariant: counters cannot overflow; pass_cnt + fail_cnt <= NUM_BLOCKS always.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE, core_clr=1 for one cycle, core_bit_vld=0, bit_rdy=0, run_done not asserted.
  - Counters keep their partial values.
  - abort has priority over every other transition, including core_done in WAIT.
- Simultaneous start and abort in IDLE: abort wins and start is dropped.
- Reset mid-run: immediate return to the reset state; no run_done.

Optional Feature:
MONOBIT_SCHED_TIMEOUT_EN
- Defined:
  - A wait counter counts cycles in WAIT. If TIMEOUT cycles elapse without core_done, timeout_err is set (sticky) and the block is counted as a fail.
  - Flow then continues through TALLY as normal.
- Not defined:
  - No wait counter is built; WAIT waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Nominal run (BLOCK_LEN=8, NUM_BLOCKS=4, MAX_FAIL=1), core returns 1,1,0,1 -> pass_cnt=3, fail_cnt=1, run_pass=1, one run_done pulse, busy low afterwards.
- Backpressure: bit_vld toggled randomly -> exactly 8 core_bit_vld pulses per block, matching the input sequence in order. core_clr pulses exactly 4 times, once before each block.
- Fail verdict: core returns 0,0,1,0 -> fail_cnt=3, run_pass=0.
- Abort after 5 bits of block 2 -> IDLE next cycle, core_clr pulse, no run_done. A following start clears the counters and completes a full 4-block run.
- Stray inputs: core_done during FEED and start during FEED are both ignored; the block still takes 8 bits and tallies only the verdict seen in WAIT.
- With MONOBIT_SCHED_TIMEOUT_EN, TIMEOUT=16 and core_done withheld on block 1 -> timeout_err=1 after 16 WAIT cycles, fail_cnt=1, run continues to run_done.
